// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// Optional build macro: MEM_ARB_PERF_EN (stall counters).
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_D
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the port arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  logic [31:0]       perf_if_stall;
  logic [31:0]       perf_d_stall;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_be,
    output perf_if_stall, perf_d_stall
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    input  perf_if_stall, perf_d_stall
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner select: D first, IF when the starvation guard trips.
// Pure combinational; the caller gates it with the grant window.
module mem_arb_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic starve_ok,
  output logic grant_if,
  output logic grant_d
);

  // priority with starvation override
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    unique case (1'b1)
      (if_req && d_req): begin
        grant_if = starve_ok;
        grant_d  = !starve_ok;
      end
      (if_req && !d_req): grant_if = 1'b1;
      (!if_req && d_req): grant_d  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-latency unified memory port shared by fetch and load/store.
// Define MEM_ARB_PERF_EN to build the IF/D stall counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW   = $clog2(MEM_LATENCY + 1);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int BE_W = DATA_W / 8;

  localparam logic [CW-1:0] LAT_C = CW'(MEM_LATENCY);
  localparam logic [SW-1:0] LIM_C = SW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  arb_owner_t    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          st_q, st_d;

  logic done, win, starve_ok;
  logic pick_if, pick_d;
  logic gnt_if, gnt_d;
  logic rv, rv_if, rv_d;

  logic [ADDR_W-1:0] addr_m;
  logic [DATA_W-1:0] wdata_m;
  logic [BE_W-1:0]   be_m;

  assign done      = (state_q == ARB_WAIT) && (cnt_q == LAT_C);
  assign win       = !rst && ((state_q == ARB_IDLE) || done);
  assign starve_ok = (starve_q >= LIM_C);

  mem_arb_pick u_pick (
    .if_req    (bus.if_req),
    .d_req     (bus.d_req),
    .starve_ok (starve_ok),
    .grant_if  (pick_if),
    .grant_d   (pick_d)
  );

  assign gnt_if = win && pick_if;
  assign gnt_d  = win && pick_d;

  assign rv    = !rst && done;
  assign rv_if = rv && (owner_q == OWNER_IF);
  assign rv_d  = rv && (owner_q == OWNER_D);

  // memory-side payload from the winner only
  always_comb begin
    addr_m  = '0;
    wdata_m = '0;
    be_m    = '0;
    unique case (1'b1)
      gnt_d: begin
        addr_m  = bus.d_addr;
        wdata_m = bus.d_wdata;
        be_m    = bus.d_be;
      end
      gnt_if: addr_m = bus.if_addr;
      default: ;
    endcase
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.mem_en    = gnt_if || gnt_d;
  assign bus.mem_we    = gnt_d && bus.d_we;
  assign bus.mem_addr  = addr_m;
  assign bus.mem_wdata = wdata_m;
  assign bus.mem_be    = be_m;

  assign bus.if_rvalid = rv_if;
  assign bus.d_rvalid  = rv_d;
  assign bus.if_rdata  = rv_if ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (rv_d && !st_q) ? bus.mem_rdata : '0;

  // next state, latency counter and starvation guard
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    starve_d = starve_q;
    if (gnt_if || gnt_d) begin
      state_d = ARB_WAIT;
      cnt_d   = CW'(1);
      owner_d = gnt_d ? OWNER_D : OWNER_IF;
      st_d    = gnt_d && bus.d_we;
    end else if (done) begin
      state_d = ARB_IDLE;
    end else if (state_q == ARB_WAIT) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (gnt_if) begin
      starve_d = '0;
    end else if (gnt_d && bus.if_req && !starve_ok) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_IF;
      cnt_q    <= '0;
      st_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      starve_q <= starve_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] pif_q, pd_q;

  // stall counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      pif_q <= '0;
      pd_q  <= '0;
    end else begin
      pif_q <= pif_q + {31'b0, bus.if_req && !gnt_if};
      pd_q  <= pd_q + {31'b0, bus.d_req && !gnt_d};
    end
  end

  assign bus.perf_if_stall = rst ? 32'd0 : pif_q;
  assign bus.perf_d_stall  = rst ? 32'd0 : pd_q;
`else
  assign bus.perf_if_stall = 32'd0;
  assign bus.perf_d_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter at latencies 1, 2 and 3.
// Table vectors, directed corner sequences, random vs. model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int L2  = 2;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b2 ();
  mem_port_arbiter_if b3 ();

  mem_port_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  mem_port_arbiter #(.MEM_LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave));
  mem_port_arbiter #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        ifr;
    logic        dr;
    logic        we;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        eig;
    logic        edg;
    logic        ewe;
    logic [31:0] eaddr;
  } vec_t;

  typedef struct {
    int due;
    bit isd;
    bit st;
  } rsp_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0;
    b1.d_addr = 0; b1.d_wdata = 0; b1.d_be = 0; b1.mem_rdata = 0;
    b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0;
    b2.d_addr = 0; b2.d_wdata = 0; b2.d_be = 0; b2.mem_rdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0;
    b3.d_addr = 0; b3.d_wdata = 0; b3.d_be = 0; b3.mem_rdata = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    vec_t tbl[7];
    rsp_t q[$];
    rsp_t r;
    int now, free_at, starve;
    logic [31:0] pif, pd;
    bit ir, dr, we, gi, gd, rvi, rvd, rs;
    logic [31:0] ia, da, wd, rd;
    logic [3:0] be;
    int k;
    bit isif;

    tbl[0] = '{ifr:1, dr:0, we:0, ia:32'h100, da:0, wd:0, be:0,
               rd:32'hDEADBEEF, eig:1, edg:0, ewe:0, eaddr:32'h100};
    tbl[1] = '{ifr:1, dr:1, we:1, ia:32'h300, da:32'h200,
               wd:32'h12345678, be:4'b0011, rd:32'hCAFEF00D,
               eig:0, edg:1, ewe:1, eaddr:32'h200};
    tbl[2] = '{ifr:0, dr:1, we:0, ia:0, da:32'h40, wd:0, be:0,
               rd:32'h0BADF00D, eig:0, edg:1, ewe:0, eaddr:32'h40};
    tbl[3] = '{ifr:1, dr:1, we:0, ia:32'h104, da:32'h44, wd:0, be:0,
               rd:32'h11112222, eig:0, edg:1, ewe:0, eaddr:32'h44};
    tbl[4] = '{ifr:0, dr:0, we:0, ia:32'h1, da:32'h2, wd:0, be:0,
               rd:32'h33334444, eig:0, edg:0, ewe:0, eaddr:0};
    tbl[5] = '{ifr:1, dr:0, we:0, ia:32'h108, da:0, wd:0, be:0,
               rd:32'h55AA55AA, eig:1, edg:0, ewe:0, eaddr:32'h108};
    tbl[6] = '{ifr:1, dr:1, we:1, ia:32'h10C, da:32'h80,
               wd:32'hA5A5A5A5, be:4'b1100, rd:32'h99999999,
               eig:0, edg:1, ewe:1, eaddr:32'h80};

    do_reset();
    #1;
    chk("reset_idle",
        {b1.if_gnt, b1.d_gnt, b1.mem_en, b1.if_rvalid, b1.d_rvalid,
         b2.mem_en, b3.mem_en}, 0);

    // table: grant cycle then completion cycle, latency 1
    for (int i = 0; i < 7; i++) begin
      b1.if_req = tbl[i].ifr; b1.if_addr = tbl[i].ia;
      b1.d_req = tbl[i].dr; b1.d_we = tbl[i].we;
      b1.d_addr = tbl[i].da; b1.d_wdata = tbl[i].wd;
      b1.d_be = tbl[i].be;
      #1;
      chk($sformatf("tbl%0d_gnt", i),
          {b1.if_gnt, b1.d_gnt, b1.mem_en, b1.mem_we},
          {tbl[i].eig, tbl[i].edg, tbl[i].eig | tbl[i].edg, tbl[i].ewe});
      chk($sformatf("tbl%0d_addr", i), b1.mem_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_wd", i), {b1.mem_wdata, b1.mem_be},
          tbl[i].edg ? {tbl[i].wd, tbl[i].be} : 36'd0);
      step();
      b1.if_req = 0; b1.d_req = 0; b1.mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_rv", i), {b1.if_rvalid, b1.d_rvalid},
          {tbl[i].eig, tbl[i].edg});
      chk($sformatf("tbl%0d_rd", i), {b1.if_rdata, b1.d_rdata},
          {tbl[i].eig ? tbl[i].rd : 32'd0,
           (tbl[i].edg && !tbl[i].ewe) ? tbl[i].rd : 32'd0});
      step();
    end

    // starvation pattern, latency 3, both held
    do_reset();
    b3.if_req = 1; b3.if_addr = 32'h500;
    b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h600;
    for (int c = 0; c < 30; c++) begin
      k = c / 3;
      isif = (k % 5) == 4;
      #1;
      chk($sformatf("starve_gnt_c%0d", c), {b3.if_gnt, b3.d_gnt},
          (c % 3 == 0) ? (isif ? 2'b10 : 2'b01) : 2'b00);
      isif = ((k - 1) % 5) == 4;
      chk($sformatf("starve_rv_c%0d", c), {b3.if_rvalid, b3.d_rvalid},
          (c >= 3 && c % 3 == 0) ? (isif ? 2'b10 : 2'b01) : 2'b00);
      @(posedge clk);
      #1;
    end

    // IF stalls five cycles while D owns the port
    do_reset();
    b3.d_req = 1; b3.d_addr = 32'h700;
    #1 chk("perf_dgnt0", {b3.if_gnt, b3.d_gnt}, 2'b01);
    step(); b3.d_req = 0; b3.if_req = 1; b3.if_addr = 32'h800;
    step();
    step(); b3.d_req = 1;
    #1 chk("perf_dgnt1", {b3.if_gnt, b3.d_gnt}, 2'b01);
    step(); b3.d_req = 0;
    step();
    step(); b3.if_req = 0;
    step();
    #1 chk("perf_cnt", {b3.perf_if_stall, b3.perf_d_stall},
           PERF ? {32'd5, 32'd0} : 64'd0);

    // reset mid-access, latency 2
    do_reset();
    b2.if_req = 1; b2.if_addr = 32'h10;
    #1 chk("rst_g0", b2.if_gnt, 1'b1);
    step();
    b2.if_req = 0; b2.d_req = 1; b2.d_addr = 32'h44; rst = 1;
    #1;
    chk("rst_zero_ctl",
        {b2.if_gnt, b2.d_gnt, b2.mem_en, b2.mem_we, b2.if_rvalid,
         b2.d_rvalid}, 0);
    chk("rst_zero_bus", {b2.mem_addr, b2.if_rdata}, 0);
    chk("rst_zero_perf", {b2.perf_if_stall, b2.perf_d_stall}, 0);
    step();
    rst = 0; b2.d_req = 0; b2.mem_rdata = 32'h77;
    #1 chk("rst_no_rv", {b2.if_rvalid, b2.d_rvalid, b2.mem_en}, 0);
    step();
    b2.if_req = 1; b2.if_addr = 32'h20;
    #1 chk("rst_regnt", {b2.if_gnt, b2.mem_addr}, {1'b1, 32'h20});
    step(); b2.if_req = 0;
    #1 chk("rst_wait", {b2.if_rvalid, b2.d_rvalid}, 0);
    step(); b2.mem_rdata = 32'h99;
    #1 chk("rst_rv", {b2.if_rvalid, b2.if_rdata}, {1'b1, 32'h99});
    step();

    // back-to-back fetches, latency 2
    do_reset();
    b2.if_req = 1; b2.if_addr = 32'h0;
    #1 chk("b2b_g0", {b2.if_gnt, b2.mem_addr}, {1'b1, 32'h0});
    step(); b2.if_addr = 32'h4;
    #1 chk("b2b_hold", b2.if_gnt, 1'b0);
    step(); b2.mem_rdata = 32'hD0D0D0D0;
    #1 chk("b2b_g1", {b2.if_gnt, b2.mem_addr, b2.if_rvalid, b2.if_rdata},
           {1'b1, 32'h4, 1'b1, 32'hD0D0D0D0});
    step(); b2.if_req = 0;
    step(); b2.mem_rdata = 32'hD1D1D1D1;
    #1 chk("b2b_rv1", {b2.if_rvalid, b2.if_rdata}, {1'b1, 32'hD1D1D1D1});
    step();

    // random traffic against a transaction-level model
    do_reset();
    now = 0; free_at = 0; starve = 0; pif = 0; pd = 0;
    ir = 0; dr = 0; we = 0; ia = 0; da = 0; wd = 0; be = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ir) begin
        ir = ($urandom_range(0, 99) < 60);
        ia = {$urandom_range(0, 1023), 2'b00};
      end
      if (!dr) begin
        dr = ($urandom_range(0, 99) < 60);
        we = $urandom_range(0, 1);
        da = $urandom;
        wd = $urandom;
        be = $urandom_range(0, 15);
      end
      rd = $urandom;
      b2.if_req = ir; b2.if_addr = ia;
      b2.d_req = dr; b2.d_we = we; b2.d_addr = da;
      b2.d_wdata = wd; b2.d_be = be; b2.mem_rdata = rd;
      gi = 0; gd = 0;
      if (now >= free_at) begin
        if (ir && dr) begin
          gi = (starve >= LIM);
          gd = !gi;
        end else begin
          gi = ir;
          gd = dr;
        end
      end
      rvi = 0; rvd = 0; rs = 0;
      if (q.size() > 0 && q[0].due == now) begin
        r = q.pop_front();
        rvi = !r.isd; rvd = r.isd; rs = r.st;
      end
      #1;
      chk("rnd_ctl",
          {b2.if_gnt, b2.d_gnt, b2.mem_en, b2.mem_we, b2.if_rvalid,
           b2.d_rvalid},
          {gi, gd, gi | gd, gd & we, rvi, rvd});
      chk("rnd_addr", b2.mem_addr, gd ? da : (gi ? ia : 32'd0));
      chk("rnd_wdata", {b2.mem_wdata, b2.mem_be},
          gd ? {wd, be} : 36'd0);
      chk("rnd_rdata", {b2.if_rdata, b2.d_rdata},
          {rvi ? rd : 32'd0, (rvd && !rs) ? rd : 32'd0});
      chk("rnd_perf", {b2.perf_if_stall, b2.perf_d_stall},
          PERF ? {pif, pd} : 64'd0);
      if (gi || gd) begin
        free_at = now + L2;
        q.push_back('{due: now + L2, isd: gd, st: gd && we});
      end
      if (gi) starve = 0;
      else if (gd && ir && starve < LIM) starve++;
      if (ir && !gi) pif++;
      if (dr && !gd) pd++;
      if (gi) ir = 0;
      if (gd) dr = 0;
      @(posedge clk);
      #1;
      now++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
